// File: rtl/smi_pkg.sv
// Shared definitions for the walking-one pin test generator and checker.
package smi_pkg;

    localparam int SMI_NBITS = 22;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } smi_state_e;

    // Next value of the walking-one sequence, truncated to nbits (nbits <= 64).
    function automatic logic [63:0] walk_nxt(input logic [63:0] x, input int nbits);
        logic [63:0] mask;
        logic [63:0] xm;
        mask = (nbits >= 64) ? '1 : ((64'd1 << nbits) - 64'd1);
        xm   = x & mask;
        return ((xm << 1) | {63'd0, (xm == 64'd0)}) & mask;
    endfunction

endpackage

// File: rtl/walk_predict.sv
// Free-running walking-one predictor: loads on seed, steps on advance.
module walk_predict
    import smi_pkg::*;
#(
    parameter int NBITS = SMI_NBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_i,
    input  logic [NBITS-1:0] seed_val_i,
    input  logic             adv_i,
    output logic [NBITS-1:0] expected_o
);

    logic [NBITS-1:0] expected_q;
    logic [NBITS-1:0] expected_d;

    always_comb begin
        expected_d = expected_q;
        if (seed_i) begin
            expected_d = seed_val_i;
        end else if (adv_i) begin
            expected_d = NBITS'(walk_nxt(64'(expected_q), NBITS));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            expected_q <= '0;
        end else begin
            expected_q <= expected_d;
        end
    end

    assign expected_o = expected_q;

endmodule

// File: rtl/smi_walk_checker.sv
// Receive-side walking-one checker: locks onto the sequence, then tracks
// mismatches as a pulse, saturating count, sticky bit mask and sticky fail.
//
// state  | meaning
// HUNT   | following pat, counting consecutive valid transitions
// LOCKED | comparing pat against the free-running predictor
module smi_walk_checker
    import smi_pkg::*;
#(
    parameter int NBITS      = SMI_NBITS,
    parameter int LOCK_COUNT = 4,
    parameter int LOST_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [NBITS-1:0] pat,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [NBITS-1:0] bad_bits,
    output logic             fail
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int LC_W = $clog2(LOST_COUNT + 1);

    smi_state_e       state_q,     state_d;
    logic [NBITS-1:0] prev_q,      prev_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [LC_W-1:0]  miss_cnt_q,  miss_cnt_d;
    logic             locked_q,    locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [NBITS-1:0] bad_bits_q,  bad_bits_d;
    logic             fail_q,      fail_d;

    logic             seed;
    logic             adv;
    logic [NBITS-1:0] expected;
    logic [NBITS-1:0] pat_nxt;
    logic [NBITS-1:0] prev_nxt;
    logic             pat_onehot0;
    logic [NBITS-1:0] diff;

    assign pat_nxt     = NBITS'(walk_nxt(64'(pat), NBITS));
    assign prev_nxt    = NBITS'(walk_nxt(64'(prev_q), NBITS));
    assign pat_onehot0 = ((pat & (pat - 1'b1)) == '0);
    assign diff        = pat ^ expected;

    walk_predict #(
        .NBITS (NBITS)
    ) u_predict (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_i     (seed),
        .seed_val_i (pat_nxt),
        .adv_i      (adv),
        .expected_o (expected)
    );

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        bad_bits_d  = bad_bits_q;
        fail_d      = fail_q;
        seed        = 1'b0;
        adv         = 1'b0;

        if (sample_en) begin
            case (state_q)
                ST_HUNT: begin
                    prev_d = pat;
                    if ((pat == prev_nxt) && pat_onehot0) begin
                        if (match_cnt_q == MC_W'(LOCK_COUNT - 1)) begin
                            state_d     = ST_LOCKED;
                            locked_d    = 1'b1;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            seed        = 1'b1;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    adv = 1'b1;
                    if (diff != '0) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        bad_bits_d = bad_bits_q | diff;
                        fail_d     = 1'b1;
                        if (miss_cnt_q == LC_W'(LOST_COUNT - 1)) begin
                            state_d     = ST_HUNT;
                            locked_d    = 1'b0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            prev_d      = pat;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // Clear beats a same-cycle mismatch for the sticky state, not the pulse.
        if (clear) begin
            err_count_d = '0;
            bad_bits_d  = '0;
            fail_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            prev_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bad_bits_q  <= '0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bad_bits_q  <= bad_bits_d;
            fail_q      <= fail_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bad_bits  = bad_bits_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_smi_walk_checker.sv
// Directed bench for smi_walk_checker; error counter narrowed so saturation is reachable quickly.
module tb_smi_walk_checker;

    localparam int NB = 22;
    localparam int EW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_en = 1'b0;
    logic          clear = 1'b0;
    logic [NB-1:0] pat = '0;
    logic          locked;
    logic          err_pulse;
    logic [EW-1:0] err_count;
    logic [NB-1:0] bad_bits;
    logic          fail;

    int            total = 0;
    int            bad = 0;
    int            pulses = 0;
    int            unlocks = 0;
    logic [NB-1:0] gen = '0;
    logic [NB-1:0] p;

    smi_walk_checker #(
        .NBITS      (NB),
        .LOCK_COUNT (4),
        .LOST_COUNT (3),
        .ERR_W      (EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .pat       (pat),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bad_bits  (bad_bits),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] gen_next(input logic [NB-1:0] g);
        if (g == '0) return 22'h000001;
        else if (g == 22'h200000) return '0;
        else return g << 1;
    endfunction

    task automatic step(input logic en, input logic [NB-1:0] pv, input logic clr);
        sample_en = en;
        pat       = pv;
        clear     = clr;
        @(posedge clk);
        #1;
        if (err_pulse) pulses++;
        if (!locked) unlocks++;
    endtask

    task automatic good();
        step(1'b1, gen, 1'b0);
        gen = gen_next(gen);
    endtask

    task automatic bad_sample(input logic [NB-1:0] pv, input logic clr);
        step(1'b1, pv, clr);
        gen = gen_next(gen);
    endtask

    initial begin
        // reset state
        rst_n = 1'b0;
        step(1'b1, 22'h3FFFFF, 1'b1);
        step(1'b0, '0, 1'b0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_pulse", 64'(err_pulse), 64'd0);
        check("rst_count", 64'(err_count), 64'd0);
        check("rst_bad", 64'(bad_bits), 64'd0);
        check("rst_fail", 64'(fail), 64'd0);

        // 1: clean sequence, lock after 5th sample
        rst_n = 1'b1;
        gen = '0;
        for (int i = 0; i < 8; i++) begin
            good();
            check("t1_lock", 64'(locked), (i >= 4) ? 64'd1 : 64'd0);
        end
        pulses = 0;
        unlocks = 0;
        for (int i = 0; i < 1000; i++) good();
        check("t1_pulses", 64'(pulses), 64'd0);
        check("t1_count", 64'(err_count), 64'd0);
        check("t1_bad", 64'(bad_bits), 64'd0);
        check("t1_unlocks", 64'(unlocks), 64'd0);

        // 2: pin 13 stuck low
        pulses = 0;
        unlocks = 0;
        for (int i = 0; i < 46; i++) bad_sample(gen & ~22'h002000, 1'b0);
        check("t2_pulses", 64'(pulses), 64'd2);
        check("t2_count", 64'(err_count), 64'd2);
        check("t2_bad", 64'(bad_bits), 64'h002000);
        check("t2_fail", 64'(fail), 64'd1);
        check("t2_unlocks", 64'(unlocks), 64'd0);
        bad_sample(gen, 1'b1);
        check("t2_clr_count", 64'(err_count), 64'd0);
        check("t2_clr_bad", 64'(bad_bits), 64'd0);
        check("t2_clr_fail", 64'(fail), 64'd0);
        check("t2_clr_locked", 64'(locked), 64'd1);

        // 3: pins 4 and 5 shorted
        pulses = 0;
        unlocks = 0;
        for (int i = 0; i < 23; i++) begin
            p = gen;
            if (gen[4] | gen[5]) p = p | 22'h000030;
            bad_sample(p, 1'b0);
        end
        check("t3_pulses", 64'(pulses), 64'd2);
        check("t3_count", 64'(err_count), 64'd2);
        check("t3_bad", 64'(bad_bits), 64'h000030);
        check("t3_fail", 64'(fail), 64'd1);
        check("t3_unlocks", 64'(unlocks), 64'd0);
        bad_sample(gen, 1'b1);

        // 4: loss of lock and relock
        for (int i = 0; i < 3; i++) begin
            bad_sample(22'h3FFFFF, 1'b0);
            check("t4_pulse", 64'(err_pulse), 64'd1);
            check("t4_locked", 64'(locked), (i < 2) ? 64'd1 : 64'd0);
        end
        check("t4_count", 64'(err_count), 64'd3);
        check("t4_bad", 64'(bad_bits), 64'h3FFFFF);
        for (int i = 0; i < 5; i++) begin
            good();
            check("t4_relock", 64'(locked), (i == 4) ? 64'd1 : 64'd0);
        end
        check("t4_hunt_count", 64'(err_count), 64'd3);
        bad_sample(gen, 1'b1);

        // 5a: random gaps in sample_en
        pulses = 0;
        unlocks = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) good();
            else step(1'b0, NB'($urandom), 1'b0);
        end
        check("t5_gap_pulses", 64'(pulses), 64'd0);
        check("t5_gap_count", 64'(err_count), 64'd0);
        check("t5_gap_unlocks", 64'(unlocks), 64'd0);

        // 5b: saturation, two misses then one hit to hold lock
        unlocks = 0;
        for (int k = 0; k < 2048 + 20; k++) begin
            bad_sample(gen ^ 22'h000001, 1'b0);
            bad_sample(gen ^ 22'h000001, 1'b0);
            good();
            if (k == 99) check("t5_sat_mid", 64'(err_count), 64'd200);
        end
        check("t5_sat", 64'(err_count), 64'hFFF);
        check("t5_sat_bad", 64'(bad_bits), 64'h000001);
        check("t5_sat_unlocks", 64'(unlocks), 64'd0);

        // 5c: clear coincident with a mismatch
        bad_sample(gen ^ 22'h000100, 1'b1);
        check("t5_clr_pulse", 64'(err_pulse), 64'd1);
        check("t5_clr_count", 64'(err_count), 64'd0);
        check("t5_clr_bad", 64'(bad_bits), 64'd0);
        check("t5_clr_fail", 64'(fail), 64'd0);
        good();
        check("t5_after_pulse", 64'(err_pulse), 64'd0);

        // 6: reset mid-run
        bad_sample(gen ^ 22'h000004, 1'b0);
        check("t6_pre_fail", 64'(fail), 64'd1);
        check("t6_pre_locked", 64'(locked), 64'd1);
        rst_n = 1'b0;
        bad_sample(gen ^ 22'h000008, 1'b0);
        check("t6_locked", 64'(locked), 64'd0);
        check("t6_pulse", 64'(err_pulse), 64'd0);
        check("t6_count", 64'(err_count), 64'd0);
        check("t6_bad", 64'(bad_bits), 64'd0);
        check("t6_fail", 64'(fail), 64'd0);
        rst_n = 1'b1;
        gen = '0;
        for (int i = 0; i < 6; i++) begin
            good();
            check("t6_relock", 64'(locked), (i >= 4) ? 64'd1 : 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
